// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, state type and helpers for the 7-segment scan decoder
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} scan_state_t;

    function automatic logic one_hot_low(input logic [NUM_DIGITS-1:0] com);
        return $countones(~com) == 1;
    endfunction

    function automatic logic [2:0] low_index(input logic [NUM_DIGITS-1:0] com);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!com[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// rtl/seg7_to_hex.sv - combinational active-low 7-segment pattern to hex nibble decoder
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       valid
);

    always_comb begin
        nibble = 4'h0;
        valid  = 1'b1;
        case (pattern)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: nibble = 4'h0;
            default:   valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - rebuilds the 32-bit value from a scanned 8-digit 7-segment display
// Optional error counter output enabled by defining SEG_SCAN_ERR_CNT_EN.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  segcom,
    input  logic [6:0]  seg,
    output logic [31:0] value,
    output logic        value_valid,
    output logic [7:0]  digit_mask,
    output logic        pattern_err,
    output logic        stale
`ifdef SEG_SCAN_ERR_CNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);
    localparam logic [23:0] TIMEOUT_MAX = 24'(TIMEOUT_CYCLES);

    // Sample layout: {segcom[7:0], seg[6:0]}
    logic [14:0] samp_meta;
    logic [14:0] samp;
    logic [14:0] samp_prev;
    logic [14:0] cap;
    logic [7:0]  stab_cnt;
    logic [7:0]  stab_next;
    logic [23:0] idle_cnt;
    logic [23:0] idle_next;
    logic [31:0] shadow;
    logic [3:0]  dec_nibble;
    logic        dec_valid;
    logic [2:0]  cap_idx;
    logic        com_ok;
    logic        good_capture;
    scan_state_t state;

    seg7_to_hex u_dec (
        .pattern (cap[6:0]),
        .nibble  (dec_nibble),
        .valid   (dec_valid)
    );

    assign com_ok       = one_hot_low(samp[14:7]);
    assign cap_idx      = low_index(cap[14:7]);
    assign good_capture = (state == CAPTURE) && dec_valid;

    assign stab_next = (samp != samp_prev)      ? 8'd1 :
                       (stab_cnt >= STABLE_MAX) ? STABLE_MAX : stab_cnt + 8'd1;

    assign idle_next = good_capture                ? 24'd0 :
                       (idle_cnt >= TIMEOUT_MAX)   ? TIMEOUT_MAX : idle_cnt + 24'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_meta <= '1;
            samp      <= '1;
            samp_prev <= '1;
            stab_cnt  <= '0;
        end else begin
            samp_meta <= {segcom, seg};
            samp      <= samp_meta;
            samp_prev <= samp;
            stab_cnt  <= stab_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cap         <= '1;
            shadow      <= '0;
            digit_mask  <= '0;
            pattern_err <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            idle_cnt    <= '0;
            stale       <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (com_ok) state <= SETTLE;
                end
                SETTLE: begin
                    if (!com_ok) begin
                        state <= IDLE;
                    end else if (stab_next == STABLE_MAX) begin
                        state <= CAPTURE;
                        cap   <= samp;
                    end
                end
                CAPTURE: begin
                    state <= HOLD;
                    if (dec_valid) begin
                        shadow[{cap_idx, 2'b00} +: 4] <= dec_nibble;
                        digit_mask[cap_idx]           <= 1'b1;
                    end else begin
                        pattern_err <= 1'b1;
                    end
                end
                HOLD: begin
                    // Re-arm only on a change so a digit is captured once per appearance
                    if (samp != cap) state <= com_ok ? SETTLE : IDLE;
                end
                default: state <= IDLE;
            endcase

            // A completing capture is always followed by HOLD, so this never collides with CAPTURE
            if (digit_mask == 8'hFF) begin
                value       <= shadow;
                value_valid <= 1'b1;
                digit_mask  <= '0;
                pattern_err <= 1'b0;
            end

            idle_cnt <= idle_next;
            stale    <= (idle_next == TIMEOUT_MAX);
        end
    end

`ifdef SEG_SCAN_ERR_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if ((state == CAPTURE) && !dec_valid && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - randomized self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  segcom = 8'hFF;
    logic [6:0]  seg = 7'h7F;
    logic [31:0] value;
    logic        value_valid;
    logic [7:0]  digit_mask;
    logic        pattern_err;
    logic        stale;
`ifdef SEG_SCAN_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pubs     = 0;

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .segcom      (segcom),
        .seg         (seg),
        .value       (value),
        .value_valid (value_valid),
        .digit_mask  (digit_mask),
        .pattern_err (pattern_err),
        .stale       (stale)
`ifdef SEG_SCAN_ERR_CNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always @(negedge clk) if (value_valid) pubs++;

    // Glyphs as lit-segment letter sets
    string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    logic [3:0]  m_nib [8];
    logic [7:0]  m_mask;
    logic        m_perr;
    int          m_pubs;
    int          m_errs;
    logic [31:0] m_value;

    function automatic logic [6:0] lit(input string s);
        logic [6:0] p;
        p = 7'h7F;
        for (int i = 0; i < s.len(); i++) p[int'(s[i]) - 97] = 1'b0;
        return p;
    endfunction

    // Returns {valid, nibble}
    function automatic logic [4:0] model_decode(input logic [6:0] p);
        if (p == 7'h7F) return 5'h10;
        for (int k = 0; k < 16; k++) begin
            if (lit(glyph[k]) == p) return {1'b1, 4'(k)};
        end
        return 5'h00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
        m_mask = 8'h00;
        m_perr = 1'b0;
        m_errs = 0;
    endtask

    task automatic model_capture(input int d, input logic [6:0] p);
        logic [4:0] r;
        r = model_decode(p);
        if (r[4]) begin
            m_nib[d]  = r[3:0];
            m_mask[d] = 1'b1;
        end else begin
            m_perr = 1'b1;
            if (m_errs < 65535) m_errs++;
        end
        if (m_mask == 8'hFF) begin
            for (int i = 0; i < 8; i++) m_value[4*i +: 4] = m_nib[i];
            m_pubs++;
            m_mask = 8'h00;
            m_perr = 1'b0;
        end
    endtask

    // Holds of 10+ cycles always capture; holds of 1-2 never reach STABLE
    task automatic show(input int d, input logic [6:0] p, input int hold, input int gap);
        segcom = ~(8'h01 << d);
        seg    = p;
        repeat (hold) @(negedge clk);
        segcom = 8'hFF;
        seg    = 7'h7F;
        repeat (gap) @(negedge clk);
        if (hold >= 8) model_capture(d, p);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".mask"}, 32'(digit_mask), 32'(m_mask));
        check({tag, ".perr"}, 32'(pattern_err), 32'(m_perr));
        check({tag, ".pubs"}, 32'(pubs), 32'(m_pubs));
        check({tag, ".value"}, value, m_value);
`ifdef SEG_SCAN_ERR_CNT_EN
        check({tag, ".errcnt"}, 32'(err_count), 32'(m_errs));
`endif
    endtask

    function automatic logic [6:0] rand_invalid();
        logic [6:0] p;
        p = 7'b0110110;
        for (int t = 0; t < 100; t++) begin
            p = 7'($urandom);
            if (!model_decode(p)[4]) break;
        end
        if (model_decode(p)[4]) p = 7'b0110110;
        return p;
    endfunction

    initial begin
        model_reset();
        m_pubs  = 0;
        m_value = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.value", value, 32'h0);
        check("rst.valid", 32'(value_valid), 32'h0);
        check("rst.stale", 32'(stale), 32'h0);
        check_state("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Full frame 1..8
        for (int i = 0; i < 8; i++) show(i, lit(glyph[i+1]), 20, 2);
        check_state("frame1");
        check("frame1.const", value, 32'h87654321);

        // Too short to settle
        show(0, lit(glyph[3]), 2, 4);
        check_state("short");

        // Invalid pattern on digit 2
        for (int i = 0; i < 8; i++) show(i, (i == 2) ? 7'b0110110 : lit(glyph[i]), 12, 2);
        check_state("badframe");
        check("badframe.perr", 32'(pattern_err), 32'h1);
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++) show(i, lit(glyph[0]), 12, 2);
        check_state("zeroframes");
        check("zeroframes.const", value, 32'h0);

        // Two commons low: ignored
        segcom = 8'hFC;
        seg    = lit(glyph[1]);
        repeat (50) @(negedge clk);
        segcom = 8'hFF;
        seg    = 7'h7F;
        repeat (2) @(negedge clk);
        check_state("twohot");

        // Timeout around 64 cycles after the capture (capture lands ~7 cycles after drive)
        show(3, lit(glyph[9]), 12, 2);
        repeat (54) @(negedge clk);
        check("stale.before", 32'(stale), 32'h0);
        repeat (6) @(negedge clk);
        check("stale.after", 32'(stale), 32'h1);
        repeat (40) @(negedge clk);
        check("stale.held", 32'(stale), 32'h1);
        show(4, lit(glyph[2]), 12, 2);
        check("stale.cleared", 32'(stale), 32'h0);
        check_state("stale");

        // Randomized scan against the model
        for (int it = 0; it < 40; it++) begin
            int d;
            int sel;
            d   = int'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       show(d, lit(glyph[$urandom_range(0, 15)]), int'($urandom_range(10, 16)), int'($urandom_range(2, 4)));
            else if (sel == 7) show(d, 7'h7F, 12, 2);
            else if (sel == 8) show(d, rand_invalid(), 12, 2);
            else               show(d, lit(glyph[$urandom_range(0, 15)]), int'($urandom_range(1, 2)), 3);
            check_state($sformatf("rand%0d", it));
        end

        // Reset mid-frame after 5 digits
        for (int i = 0; i < 5; i++) show(i, lit(glyph[i+10]), 12, 2);
        #2 reset = 1'b0;
        #1;
        check("midrst.value", value, 32'h0);
        check("midrst.mask", 32'(digit_mask), 32'h0);
        check("midrst.perr", 32'(pattern_err), 32'h0);
        check("midrst.stale", 32'(stale), 32'h0);
        model_reset();
        m_value = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) show(i, lit(glyph[15]), 12, 2);
        check_state("afterrst");
        check("afterrst.const", value, 32'hFFFFFFFF);

`ifdef SEG_SCAN_ERR_CNT_EN
        for (int i = 0; i < 3; i++) show(i, rand_invalid(), 12, 2);
        check("errcnt.three", 32'(err_count), 32'd3);
        check_state("errcnt");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 8-digit 7-segment display driver.
- Samples the scanned common lines `segcom` and segment lines `seg`, and decodes each stable digit pattern back to a hex nibble.
- Reassembles the 32-bit value shown on the display and publishes it once every digit has been seen in a scan frame.
- Used as an on-chip display monitor and as a self-checking element in counter/display benches.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples of {segcom,seg} required before a digit is accepted (range 1..255).
- TIMEOUT_CYCLES, 1000000, cycles without any accepted digit before `stale` asserts (range 16..2^24-1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- segcom  input  8  digit commons, active-low one-hot; bit i selects digit i, and digit 0 is value[3:0].
- seg  input  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- value  output  32  last published display value.
- value_valid  output  1  one-cycle pulse when `value` updates.
- digit_mask  output  8  digits accepted in the current frame.
- pattern_err  output  1  sticky: a non-hex segment pattern was seen since the last publish.
- stale  output  1  no digit accepted for TIMEOUT_CYCLES.

Behaviour:
- Reset values:
  - value=0, value_valid=0, digit_mask=0, pattern_err=0, stale=0.
  - Synchronizers and internal shadow register cleared.
- Input sync:
  - segcom and seg pass through 2-FF synchronizers; the synchronizer reset value is all-ones.
  - All decisions below use the synchronized samples.
- Stability counter:
  - Reloads to 1 whenever the synchronized {segcom,seg} differs from the previous cycle; otherwise increments and saturates at STABLE_CYCLES.
- FSM:
  - IDLE: segcom not exactly one-hot-low (all high, or several low).
    - Go to SETTLE when exactly one bit is low.
  - SETTLE: waiting for stability.
    - Go to CAPTURE when the counter reaches STABLE_CYCLES.
    - Go to IDLE if segcom becomes invalid.
  - CAPTURE: lasts 1 cycle and decodes the digit.
    - Valid pattern: write the nibble into shadow[4i+3:4i] and set digit_mask[i].
    - Invalid pattern: set pattern_err and leave mask and shadow unchanged.
    - Always go to HOLD.
  - HOLD: wait while {segcom,seg} is unchanged.
    - Any change goes to SETTLE if segcom is still one-hot, otherwise to IDLE.
    - Each visible digit is therefore captured at most once per appearance.
- Decode table (active-high segment set → nibble):
  - abcdef→0, bc→1, abdeg→2, abcdg→3, bcfg→4, acdfg→5, acdefg→6, abc→7.
  - abcdefg→8, abcdfg→9, abcefg→A, cdefg→b, adef→C, bcdeg→d, adefg→E, aefg→F.
  - All segments off (blank) decodes as 0.
  - Any other pattern is invalid.
- Publish:
  - The cycle after digit_mask becomes 8'hFF: value←shadow, value_valid=1 for 1 cycle, digit_mask←0, pattern_err←0.
  - Shadow is retained, so digits persist into the next frame.
- Recapture: a digit re-captured before the frame completes overwrites its nibble (last capture wins).
- Timeout:
  - Idle counter clears on every CAPTURE with a valid pattern and otherwise saturates at TIMEOUT_CYCLES.
  - stale=1 while saturated.
  - stale clears in the same cycle as the next valid capture.
- Simultaneous events: a CAPTURE that completes the mask and the publish never coincide; the publish is always the following cycle.
- Mid-operation reset: all outputs return to reset values asynchronously, and no partial frame is published afterwards.

Optional Feature:
- SEG_SCAN_ERR_CNT_EN defined:
  - Adds output err_count[15:0], reset 0.
  - Increments on every invalid-pattern CAPTURE and saturates at 16'hFFFF.
  - Not cleared by publish.
- Undefined: the port and counter are absent; pattern_err is the only error indication.

Decomposition:
- Shared package seg_pkg:
  - Active-low segment constants SEG_0..SEG_F and SEG_BLANK.
  - FSM state typedef {IDLE, SETTLE, CAPTURE, HOLD}.
  - NUM_DIGITS=8.
- One sub-module: seg7_to_hex, purely combinational. Input 7-bit pattern; outputs nibble[3:0] and valid. Reusable by other display checkers.

Test Plan:
- Release reset; scan digits 0..7 with patterns for 1,2,3,4,5,6,7,8, each held 20 cycles with a 2-cycle blank gap → value_valid pulses once, value=32'h87654321, pattern_err=0.
- Hold segcom=8'hFE, seg=SEG_3 for only 2 cycles with STABLE_CYCLES=4 → no capture, digit_mask stays 0.
- Inject seg=7'b0110110 on digit 2 within a full frame → pattern_err=1 and digit 2 is not set; a second frame of all SEG_0 then publishes value=0 and clears pattern_err.
- Drive segcom=8'hFC (two digits low) for 50 cycles → FSM stays IDLE, no mask change.
- With TIMEOUT_CYCLES=64, stop scanning for 100 cycles → stale=1 from cycle 64 after the last valid capture; the next valid digit clears it.
- Assert reset low mid-frame after 5 digits, then release and scan a full frame of SEG_F → a single publish with value=32'hFFFFFFFF. With SEG_SCAN_ERR_CNT_EN defined, 3 invalid digits give err_count=3.
